// File: rtl/intan_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : intan_cmd_sequencer
// Purpose  : Issues Intan init/calibrate/CONVERT commands per SPI frame and
//            routes each returned word to the command issued two frames back.
// Revision : 1.0
// ============================================================================
module intan_cmd_sequencer #(
   parameter int          NUM_CH       = 32,
   parameter int          INIT_DUMMIES = 2,
   parameter int          CAL_DUMMIES  = 9,
   parameter logic [15:0] AUX_CMD      = 16'hE800
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        frame_done,
   input  logic [15:0] result,
   output logic [15:0] command,
   output logic        interface_on,
   output logic [15:0] sample_data,
   output logic [5:0]  sample_channel,
   output logic        sample_valid,
   output logic [15:0] aux_data,
   output logic        aux_valid,
   output logic        sweep_start,
   output logic        busy_init
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_INIT_DUMMY = 3'd1,
      ST_CAL        = 3'd2,
      ST_CAL_DUMMY  = 3'd3,
      ST_RUN        = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      K_NONE = 2'd0,
      K_CONV = 2'd1,
      K_AUX  = 2'd2
   } kind_t;

   typedef struct packed {
      kind_t      kind;
      logic [5:0] ch;
   } tag_t;

   localparam logic [15:0] c_DUMMY    = 16'hFF00;
   localparam logic [15:0] c_CALIB    = 16'h5500;
   localparam logic [15:0] c_INIT_N   = 16'(INIT_DUMMIES);
   localparam logic [15:0] c_CAL_N    = 16'(CAL_DUMMIES);
   localparam logic [5:0]  c_LAST_CH  = 6'(NUM_CH - 1);
   localparam tag_t        c_TAG_NONE = '{kind: K_NONE, ch: 6'd0};

   state_t      r_state, w_state_nxt;
   logic [15:0] r_count, w_count_nxt;
   logic [5:0]  r_ch, w_ch_nxt;
   tag_t        r_tag_cur, r_tag_d1, r_tag_d2, w_tag_nxt;
   logic [15:0] w_cmd_nxt;
   logic        w_iface_nxt;
   logic        w_sweep_nxt;
   logic        w_flush;

   function automatic logic [15:0] convert(input logic [5:0] c);
      return {2'b00, c, 8'h00};
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_ch_nxt    = r_ch;
      w_cmd_nxt   = command;
      w_iface_nxt = interface_on;
      w_tag_nxt   = c_TAG_NONE;
      w_sweep_nxt = 1'b0;
      w_flush     = 1'b0;

      if (r_state != ST_IDLE && !enable) begin
         // Drop out of acquisition; in-flight results are discarded.
         w_state_nxt = ST_IDLE;
         w_cmd_nxt   = 16'h0000;
         w_iface_nxt = 1'b0;
         w_count_nxt = 16'd0;
         w_ch_nxt    = 6'd0;
         w_flush     = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable) begin
                  w_iface_nxt = 1'b1;
                  w_count_nxt = 16'd1;
                  if (c_INIT_N == 16'd0) begin
                     w_cmd_nxt   = c_CALIB;
                     w_state_nxt = ST_CAL;
                  end else begin
                     w_cmd_nxt   = c_DUMMY;
                     w_state_nxt = ST_INIT_DUMMY;
                  end
               end
            end
            ST_INIT_DUMMY: begin
               if (r_count < c_INIT_N) begin
                  w_cmd_nxt   = c_DUMMY;
                  w_count_nxt = r_count + 16'd1;
               end else begin
                  w_cmd_nxt   = c_CALIB;
                  w_state_nxt = ST_CAL;
               end
            end
            ST_CAL: begin
               if (c_CAL_N == 16'd0) begin
                  w_cmd_nxt   = convert(6'd0);
                  w_ch_nxt    = 6'd0;
                  w_tag_nxt   = '{kind: K_CONV, ch: 6'd0};
                  w_sweep_nxt = 1'b1;
                  w_state_nxt = ST_RUN;
               end else begin
                  w_cmd_nxt   = c_DUMMY;
                  w_count_nxt = 16'd1;
                  w_state_nxt = ST_CAL_DUMMY;
               end
            end
            ST_CAL_DUMMY: begin
               if (r_count < c_CAL_N) begin
                  w_cmd_nxt   = c_DUMMY;
                  w_count_nxt = r_count + 16'd1;
               end else begin
                  w_cmd_nxt   = convert(6'd0);
                  w_ch_nxt    = 6'd0;
                  w_tag_nxt   = '{kind: K_CONV, ch: 6'd0};
                  w_sweep_nxt = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               // The aux slot is identified by the tag of the command just issued.
               if (r_tag_cur.kind == K_AUX) begin
                  w_cmd_nxt   = convert(6'd0);
                  w_ch_nxt    = 6'd0;
                  w_tag_nxt   = '{kind: K_CONV, ch: 6'd0};
                  w_sweep_nxt = 1'b1;
               end else if (r_ch < c_LAST_CH) begin
                  w_ch_nxt  = r_ch + 6'd1;
                  w_cmd_nxt = convert(r_ch + 6'd1);
                  w_tag_nxt = '{kind: K_CONV, ch: r_ch + 6'd1};
               end else begin
                  w_cmd_nxt = AUX_CMD;
                  w_tag_nxt = '{kind: K_AUX, ch: 6'd0};
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cmd_nxt   = 16'h0000;
               w_iface_nxt = 1'b0;
               w_flush     = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_count        <= 16'd0;
         r_ch           <= 6'd0;
         r_tag_cur      <= c_TAG_NONE;
         r_tag_d1       <= c_TAG_NONE;
         r_tag_d2       <= c_TAG_NONE;
         command        <= 16'h0000;
         interface_on   <= 1'b0;
         sample_data    <= 16'h0000;
         sample_channel <= 6'd0;
         sample_valid   <= 1'b0;
         aux_data       <= 16'h0000;
         aux_valid      <= 1'b0;
         sweep_start    <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         aux_valid    <= 1'b0;
         sweep_start  <= 1'b0;
         if (frame_done) begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_ch         <= w_ch_nxt;
            command      <= w_cmd_nxt;
            interface_on <= w_iface_nxt;
            sweep_start  <= w_sweep_nxt;
            if (w_flush) begin
               r_tag_cur <= c_TAG_NONE;
               r_tag_d1  <= c_TAG_NONE;
               r_tag_d2  <= c_TAG_NONE;
            end else begin
               if (r_tag_d2.kind == K_CONV) begin
                  sample_data    <= result;
                  sample_channel <= r_tag_d2.ch;
                  sample_valid   <= 1'b1;
               end else if (r_tag_d2.kind == K_AUX) begin
                  aux_data  <= result;
                  aux_valid <= 1'b1;
               end
               r_tag_d2  <= r_tag_d1;
               r_tag_d1  <= r_tag_cur;
               r_tag_cur <= w_tag_nxt;
            end
         end
      end
   end

   assign busy_init = (r_state == ST_INIT_DUMMY) || (r_state == ST_CAL) ||
                      (r_state == ST_CAL_DUMMY);

endmodule
`default_nettype wire

// File: tb/tb_intan_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_intan_cmd_sequencer
// Purpose  : Self-checking bench for intan_cmd_sequencer (NUM_CH=4 and 1).
// Revision : 1.0
// ============================================================================
module tb_intan_cmd_sequencer;

   localparam int c_L = 12;

   typedef struct {
      logic [15:0] cmd;
      logic        busy;
      logic        sweep;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, enable, frame_done;
   logic [15:0] result;

   logic [15:0] command4, sample_data4, aux_data4;
   logic [5:0]  sample_channel4;
   logic        interface_on4, sample_valid4, aux_valid4, sweep_start4, busy_init4;
   logic [15:0] command1, sample_data1, aux_data1;
   logic [5:0]  sample_channel1;
   logic        interface_on1, sample_valid1, aux_valid1, sweep_start1, busy_init1;

   int n_checks = 0;
   int n_fail   = 0;
   bit active   = 1'b0;
   int idx      = 0;
   vec_t tbl[18];

   always #5 clk = ~clk;

   intan_cmd_sequencer #(.NUM_CH(4)) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .frame_done(frame_done), .result(result),
      .command(command4), .interface_on(interface_on4), .sample_data(sample_data4),
      .sample_channel(sample_channel4), .sample_valid(sample_valid4), .aux_data(aux_data4),
      .aux_valid(aux_valid4), .sweep_start(sweep_start4), .busy_init(busy_init4));

   intan_cmd_sequencer #(.NUM_CH(1)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .frame_done(frame_done), .result(result),
      .command(command1), .interface_on(interface_on1), .sample_data(sample_data1),
      .sample_channel(sample_channel1), .sample_valid(sample_valid1), .aux_data(aux_data1),
      .aux_valid(aux_valid1), .sweep_start(sweep_start1), .busy_init(busy_init1));

   // Command m since start: 12 init/cal words, then repeating [CONV 0..nch-1, AUX].
   function automatic int kind_of(input int m, input int nch);
      if (m < c_L) return 0;
      return (((m - c_L) % (nch + 1)) < nch) ? 1 : 2;
   endfunction

   function automatic int ch_of(input int m, input int nch);
      if (m < c_L) return 0;
      return (m - c_L) % (nch + 1);
   endfunction

   function automatic logic [15:0] cmd_of(input int m, input int nch);
      if (m == 2) return 16'h5500;
      if (m < c_L) return 16'hFF00;
      if (kind_of(m, nch) == 1) return 16'(ch_of(m, nch) * 256);
      return 16'hE800;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(input string t, input int nch, input logic [15:0] res,
                            input logic [15:0] cmd, input logic iface, input logic busy,
                            input logic sweep, input logic sv, input logic av,
                            input logic [15:0] sd, input logic [5:0] sc, input logic [15:0] ad);
      int k;
      if (active) begin
         k = (idx >= 3) ? kind_of(idx - 3, nch) : 0;
         chk({t, " command"}, cmd, cmd_of(idx, nch));
         chk({t, " interface_on"}, 16'(iface), 16'd1);
         chk({t, " busy_init"}, 16'(busy), 16'(idx < c_L));
         chk({t, " sweep_start"}, 16'(sweep), 16'(kind_of(idx, nch) == 1 && ch_of(idx, nch) == 0));
         chk({t, " sample_valid"}, 16'(sv), 16'(k == 1));
         chk({t, " aux_valid"}, 16'(av), 16'(k == 2));
         if (k == 1) begin
            chk({t, " sample_data"}, sd, res);
            chk({t, " sample_channel"}, 16'(sc), 16'(ch_of(idx - 3, nch)));
         end
         if (k == 2) chk({t, " aux_data"}, ad, res);
      end else begin
         chk({t, " idle command"}, cmd, 16'h0000);
         chk({t, " idle interface_on"}, 16'(iface), 16'd0);
         chk({t, " idle busy_init"}, 16'(busy), 16'd0);
         chk({t, " idle strobes"}, {13'd0, sweep, sv, av}, 16'd0);
      end
   endtask

   task automatic do_event(input logic en, input logic [15:0] res);
      @(negedge clk);
      enable     = en;
      frame_done = 1'b1;
      result     = res;
      @(posedge clk);
      #1;
      frame_done = 1'b0;
      if (!active && en) begin
         active = 1'b1;
         idx    = 0;
      end else if (active && !en) begin
         active = 1'b0;
      end else if (active) begin
         idx++;
      end
      check_dut("n4", 4, res, command4, interface_on4, busy_init4, sweep_start4,
                sample_valid4, aux_valid4, sample_data4, sample_channel4, aux_data4);
      check_dut("n1", 1, res, command1, interface_on1, busy_init1, sweep_start1,
                sample_valid1, aux_valid1, sample_data1, sample_channel1, aux_data1);
      @(posedge clk);
      #1;
      chk("strobe self-clear", {10'd0, sweep_start4, sample_valid4, aux_valid4,
          sweep_start1, sample_valid1, aux_valid1}, 16'd0);
   endtask

   // Bench-side result source: {A0, ch} for conversions, a marker for aux.
   function automatic logic [15:0] stub(input int m);
      if (m < 3) return 16'h1234;
      if (kind_of(m - 3, 4) == 1) return 16'hA000 | 16'(ch_of(m - 3, 4));
      if (kind_of(m - 3, 4) == 2) return 16'hBEEF;
      return 16'h1234;
   endfunction

   task automatic check_reset_outputs();
      chk("rst command", command4 | command1, 16'h0000);
      chk("rst interface_on", {14'd0, interface_on4, interface_on1}, 16'd0);
      chk("rst strobes", {10'd0, sample_valid4, aux_valid4, sweep_start4,
          sample_valid1, aux_valid1, sweep_start1}, 16'd0);
      chk("rst busy_init", {14'd0, busy_init4, busy_init1}, 16'd0);
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      frame_done = 1'b0;
      result     = 16'h0000;

      for (int i = 0; i < 18; i++) begin
         tbl[i].cmd   = 16'hFF00;
         tbl[i].busy  = (i < 12);
         tbl[i].sweep = (i == 12 || i == 17);
      end
      tbl[2].cmd  = 16'h5500;
      tbl[12].cmd = 16'h0000;
      tbl[13].cmd = 16'h0100;
      tbl[14].cmd = 16'h0200;
      tbl[15].cmd = 16'h0300;
      tbl[16].cmd = 16'hE800;
      tbl[17].cmd = 16'h0000;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      chk("rst sample_data", sample_data4 | aux_data4, 16'h0000);
      @(negedge clk);
      reset = 1'b0;

      do_event(1'b0, 16'h5A5A);
      do_event(1'b0, 16'hA5A5);

      for (int i = 0; i < 18; i++) begin
         do_event(1'b1, stub(active ? idx + 1 : 0));
         chk("tbl command", command4, tbl[i].cmd);
         chk("tbl busy_init", 16'(busy_init4), 16'(tbl[i].busy));
         if (i == 15) begin
            chk("first sample data", sample_data4, 16'hA000);
            chk("first sample channel", 16'(sample_channel4), 16'd0);
         end
      end
      for (int i = 0; i < 4; i++) do_event(1'b1, stub(idx + 1));

      // Asynchronous reset right after an event, while strobes may be high.
      @(negedge clk);
      enable     = 1'b1;
      frame_done = 1'b1;
      result     = 16'h7777;
      @(posedge clk);
      #1;
      frame_done = 1'b0;
      reset      = 1'b1;
      #1;
      check_reset_outputs();
      active = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      do_event(1'b0, 16'h1111);
      repeat (4) @(posedge clk);
      #1;
      chk("post-reset quiet", {15'd0, interface_on4}, 16'd0);

      // Drop enable at the event that would issue CONVERT(2), then restart.
      for (int i = 0; i < 14; i++) do_event(1'b1, stub(active ? idx + 1 : 0));
      do_event(1'b0, 16'hDEAD);
      for (int i = 0; i < 18; i++) do_event(1'b1, stub(active ? idx + 1 : 0));

      for (int i = 0; i < 400; i++) begin
         do_event(($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0, 16'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
